gsim_residual_check: RTL and testbench
======================================

// Module: gsim_residual_check
// PURPOSE
//  Downstream checker for the Gauss-Seidel solver. Snoops the solver's input bus (in_en/b_in)
//  to capture b, captures the solver's serial x stream (out_valid/x_out), then computes
//  r = b - A*x for the fixed 16x16 band matrix (diag 20, +-1: -13, +-2: 6, +-3: -1).
//  Streams the residuals and reports max |r| and a pass flag against a tolerance.
// PARAMETERS
//  N    16            system size; index width = 4 (fixed for N=16)
//  TOL  32'h0000_0100 pass threshold on max|r|, Q16.16 (2^-8)
// PORTS
//  clk        in   1   clock, rising edge
//  reset      in   1   asynchronous, active-high reset
//  in_en      in   1   solver input strobe, one b value per cycle
//  b_in       in   16  b_i, signed integer, b_1 first
//  out_valid  in   1   solver output strobe, one x value per cycle
//  x_in       in   32  x_i, signed Q16.16, x_1 first (solver x_out)
//  r_valid    out  1   r_out/r_idx valid this cycle
//  r_out      out  32  residual r_i, signed Q16.16, saturated
//  r_idx      out  4   row index i-1 (0..15)
//  done       out  1   one-cycle pulse after last residual
//  max_abs    out  32  max |r_i| of last problem, Q16.16
//  pass       out  1   max_abs <= TOL, valid from done
//  err        out  1   sticky protocol error
// BEHAVIOUR
//  Reset: all outputs 0, FSM=LOAD_B, counters 0, b/x buffers 0. Async: outputs clear at once.
//  FSM LOAD_B -> LOAD_X -> CALC -> LOAD_B.
//  LOAD_B: each in_en cycle stores b_in at bcnt, bcnt++; first accept clears max_abs/pass.
//   16th accept -> LOAD_X. out_valid here: ignored, err<=1.
//  LOAD_X: each out_valid cycle stores x_in at xcnt; 16th -> CALC. in_en here: ignored, err<=1.
//  in_en and out_valid same cycle: the strobe legal for the state is taken, other sets err.
//  CALC: row c=0..15, one per cycle, 16 cycles, no stalls. Row c registered into
//   r_out/r_idx=c/r_valid=1 on the edge ending that cycle; first r_valid the cycle after the
//   16th x accept. done=1 the cycle after r_idx=15 (r_valid=0), FSM back in LOAD_B.
//   Strobes during CALC: ignored, err<=1.
//  Arithmetic: 40-bit signed accumulator. B = sign-extend({b,16'b0}).
//   acc = B_c - (20x_c - 13(x_c-1 + x_c+1) + 6(x_c-2 + x_c+2) - (x_c-3 + x_c+3)).
//   Out-of-range neighbours (index <0 or >15) contribute 0. Constant multiplies by shift/add.
//   r_out = sat32(acc): >0x7FFF_FFFF -> 0x7FFF_FFFF, <-0x8000_0000 -> 0x8000_0000.
//   |r| from saturated r_out; |0x8000_0000| = 0x7FFF_FFFF.
//   max_abs updated each r_valid row; pass = (max_abs <= TOL) set with done.
//  max_abs/pass hold until first b of next problem. err clears only on reset.
//  Reset mid-CALC: r_valid drops immediately, no done; next problem starts from LOAD_B.
// TESTING
//  1 b=0, x=0 -> 16 r_valid, r_out=0 all rows, r_idx 0..15, done, max_abs=0, pass=1.
//  2 b_1=20, rest 0; x_1=0x0001_0000, rest 0 -> r: row0 0, row1 0x000D_0000, row2 0xFFFA_0000,
//    row3 0x0001_0000, rest 0; max_abs=0x000D_0000, pass=0.
//  3 b=0, x all 0x7FFF_FFFF -> interior rows saturate to 0x8000_0000; max_abs=0x7FFF_FFFF.
//  4 TOL=0x0001_0000, x=0: b_5=1 -> max_abs=0x0001_0000, pass=1; b_5=2 -> pass=0.
//  5 reset after 5th r_valid -> outputs 0 at once, no done; rerun test 2 -> same results.
//  6 out_valid during LOAD_B (bcnt=3) -> err=1, x ignored; in_en in CALC -> ignored, err held.

Source files
------------

// File: rtl/gsim_residual_check.sv
// Residual checker for the Gauss-Seidel solver: captures b and x, then
// streams r = b - A*x for the 16x16 band matrix with max|r| and a pass flag.
module gsim_residual_check #(
  parameter int          N   = 16,
  parameter logic [31:0] TOL = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_in_en,
  input  logic [15:0] i_b_in,
  input  logic        i_out_valid,
  input  logic [31:0] i_x_in,
  output logic        o_r_valid,
  output logic [31:0] o_r_out,
  output logic [3:0]  o_r_idx,
  output logic        o_done,
  output logic [31:0] o_max_abs,
  output logic        o_pass,
  output logic        o_err
);

  typedef enum logic [1:0] {
    S_LOAD_B,
    S_LOAD_X,
    S_CALC
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [15:0] r_b [N];
  logic [31:0] r_x [N];
  logic [3:0]  r_bcnt;
  logic [3:0]  r_xcnt;
  logic [3:0]  r_ccnt;

  logic w_b_acc;
  logic w_x_acc;
  logic w_calc;
  logic w_perr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_LOAD_B;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_b_acc = 1'b0;
    w_x_acc = 1'b0;
    w_calc  = 1'b0;
    w_perr  = 1'b0;
    unique case (r_state)
      S_LOAD_B: begin
        w_b_acc = i_in_en;
        w_perr  = i_out_valid;
        if (i_in_en && r_bcnt == 4'd15) w_next = S_LOAD_X;
      end
      S_LOAD_X: begin
        w_x_acc = i_out_valid;
        w_perr  = i_in_en;
        if (i_out_valid && r_xcnt == 4'd15) w_next = S_CALC;
      end
      S_CALC: begin
        w_calc = 1'b1;
        w_perr = i_in_en | i_out_valid;
        if (r_ccnt == 4'd15) w_next = S_LOAD_B;
      end
      default: w_next = S_LOAD_B;
    endcase
  end

  // x padded with three zeros each side so edge rows need no special case
  logic signed [39:0] w_xp [N+6];
  logic        [4:0]  w_c;
  logic signed [39:0] w_x0;
  logic signed [39:0] w_s1;
  logic signed [39:0] w_s2;
  logic signed [39:0] w_s3;
  logic signed [39:0] w_ax;
  logic signed [39:0] w_bb;
  logic signed [39:0] w_acc;
  logic        [15:0] w_bc;
  logic               w_hi;
  logic               w_lo;
  logic        [31:0] w_sat;
  logic        [31:0] w_abs;

  always_comb begin
    for (int k = 0; k < N + 6; k++) w_xp[k] = '0;
    for (int k = 0; k < N; k++)
      w_xp[k+3] = {{8{r_x[k][31]}}, r_x[k]};
  end

  always_comb begin
    w_c  = {1'b0, r_ccnt};
    w_x0 = w_xp[w_c + 5'd3];
    w_s1 = w_xp[w_c + 5'd2] + w_xp[w_c + 5'd4];
    w_s2 = w_xp[w_c + 5'd1] + w_xp[w_c + 5'd5];
    w_s3 = w_xp[w_c]        + w_xp[w_c + 5'd6];
    w_ax = (w_x0 <<< 4) + (w_x0 <<< 2)
         - ((w_s1 <<< 3) + (w_s1 <<< 2) + w_s1)
         + (w_s2 <<< 2) + (w_s2 <<< 1)
         - w_s3;
    w_bc  = r_b[r_ccnt];
    w_bb  = {{8{w_bc[15]}}, w_bc, 16'h0000};
    w_acc = w_bb - w_ax;
    w_hi  = !w_acc[39] && (|w_acc[38:31]);
    w_lo  = w_acc[39] && !(&w_acc[38:31]);
    if (w_hi)      w_sat = 32'h7FFF_FFFF;
    else if (w_lo) w_sat = 32'h8000_0000;
    else           w_sat = w_acc[31:0];
    if (!w_sat[31])                  w_abs = w_sat;
    else if (w_sat == 32'h8000_0000) w_abs = 32'h7FFF_FFFF;
    else                             w_abs = -w_sat;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < N; k++) begin
        r_b[k] <= '0;
        r_x[k] <= '0;
      end
      r_bcnt    <= '0;
      r_xcnt    <= '0;
      r_ccnt    <= '0;
      o_r_valid <= 1'b0;
      o_r_out   <= '0;
      o_r_idx   <= '0;
      o_done    <= 1'b0;
      o_max_abs <= '0;
      o_pass    <= 1'b0;
      o_err     <= 1'b0;
    end else begin
      o_r_valid <= w_calc;
      o_done    <= o_r_valid && o_r_idx == 4'd15;
      if (o_r_valid && o_r_idx == 4'd15)
        o_pass <= o_max_abs <= TOL;
      if (w_calc) begin
        o_r_out <= w_sat;
        o_r_idx <= r_ccnt;
        r_ccnt  <= r_ccnt + 4'd1;
        if (w_abs > o_max_abs) o_max_abs <= w_abs;
      end
      if (w_x_acc) begin
        r_x[r_xcnt] <= i_x_in;
        r_xcnt      <= r_xcnt + 4'd1;
      end
      // a new problem's first b wipes the previous verdict
      if (w_b_acc) begin
        r_b[r_bcnt] <= i_b_in;
        r_bcnt      <= r_bcnt + 4'd1;
        if (r_bcnt == 4'd0) begin
          o_max_abs <= '0;
          o_pass    <= 1'b0;
        end
      end
      if (w_perr) o_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_gsim_residual_check.sv
// Randomised bench for gsim_residual_check against a plain-arithmetic
// band-matrix residual model.
module tb_gsim_residual_check;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_en;
  logic [15:0] b_in;
  logic        out_valid;
  logic [31:0] x_in;

  logic        r_valid, done, pass, err;
  logic [31:0] r_out, max_abs;
  logic [3:0]  r_idx;
  logic        t_r_valid, t_done, t_pass, t_err;
  logic [31:0] t_r_out, t_max_abs;
  logic [3:0]  t_r_idx;

  gsim_residual_check dut (
    .clk(clk), .reset(reset),
    .i_in_en(in_en), .i_b_in(b_in),
    .i_out_valid(out_valid), .i_x_in(x_in),
    .o_r_valid(r_valid), .o_r_out(r_out), .o_r_idx(r_idx),
    .o_done(done), .o_max_abs(max_abs), .o_pass(pass), .o_err(err)
  );

  gsim_residual_check #(.TOL(32'h0001_0000)) dut_t (
    .clk(clk), .reset(reset),
    .i_in_en(in_en), .i_b_in(b_in),
    .i_out_valid(out_valid), .i_x_in(x_in),
    .o_r_valid(t_r_valid), .o_r_out(t_r_out), .o_r_idx(t_r_idx),
    .o_done(t_done), .o_max_abs(t_max_abs), .o_pass(t_pass),
    .o_err(t_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  logic [15:0] mb [16];
  logic [31:0] mx [16];

  function automatic logic [31:0] ref_r(input int i);
    longint acc, cf;
    int d;
    acc = longint'($signed(mb[i])) * 65536;
    for (int j = 0; j < 16; j++) begin
      d = (i > j) ? i - j : j - i;
      cf = (d == 0) ? 20 : (d == 1) ? -13 : (d == 2) ? 6 : (d == 3) ? -1 : 0;
      acc -= cf * longint'($signed(mx[j]));
    end
    if (acc > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (acc < -64'sd2147483648) return 32'h8000_0000;
    return acc[31:0];
  endfunction

  function automatic logic [31:0] ref_abs(input logic [31:0] r);
    if (r == 32'h8000_0000) return 32'h7FFF_FFFF;
    return r[31] ? -r : r;
  endfunction

  function automatic logic [31:0] ref_max();
    logic [31:0] m = 0;
    for (int i = 0; i < 16; i++)
      if (ref_abs(ref_r(i)) > m) m = ref_abs(ref_r(i));
    return m;
  endfunction

  task automatic set_zero();
    for (int i = 0; i < 16; i++) begin
      mb[i] = 0;
      mx[i] = 0;
    end
  endtask

  task automatic set_t2();
    set_zero();
    mb[0] = 16'd20;
    mx[0] = 32'h0001_0000;
  endtask

  task automatic set_rand();
    for (int i = 0; i < 16; i++) begin
      mb[i] = 16'($urandom);
      if ($urandom_range(1, 0) == 1) mx[i] = $urandom;
      else mx[i] = 32'($signed(16'($urandom))) <<< 4;
    end
  endtask

  task automatic send(input int gap, input bit stray);
    for (int i = 0; i < 16; i++) begin
      repeat ($urandom_range(gap, 0)) @(negedge clk);
      if (stray && i == 3) begin
        out_valid = 1'b1;
        x_in = 32'hDEAD_BEEF;
        @(negedge clk);
        out_valid = 1'b0;
        check("err_in_loadb", 32'(err), 1);
      end
      in_en = 1'b1;
      b_in = mb[i];
      @(negedge clk);
      in_en = 1'b0;
    end
    for (int i = 0; i < 16; i++) begin
      repeat ($urandom_range(gap, 0)) @(negedge clk);
      out_valid = 1'b1;
      x_in = mx[i];
      @(negedge clk);
      out_valid = 1'b0;
    end
  endtask

  task automatic collect(input string tag, input bit poke,
                         input int abort_at, input bit exp_err);
    int rows = 0;
    int first = -1;
    int dcyc = -1;
    int ndone = 0;
    int stray = 0;
    for (int c = 0; c < 40; c++) begin
      if (r_valid) begin
        if (rows == 0) first = c;
        check({tag, " r_idx"}, 32'(r_idx), 32'(rows));
        check({tag, " r_out"}, r_out, ref_r(rows & 15));
        check({tag, " row_cycle"}, 32'(c), 32'(first + rows));
        rows++;
      end
      if (done) begin
        ndone++;
        dcyc = c;
        check({tag, " r_valid_at_done"}, 32'(r_valid), 0);
      end
      if (abort_at > 0 && rows == abort_at) begin
        reset = 1'b1;
        #1;
        check({tag, " rst_r_valid"}, 32'(r_valid), 0);
        check({tag, " rst_r_out"}, r_out, 0);
        check({tag, " rst_max_abs"}, max_abs, 0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
          @(negedge clk);
          stray += int'(r_valid) + int'(done);
        end
        check({tag, " quiet_after_rst"}, 32'(stray), 0);
        return;
      end
      in_en = poke && c == 3;
      b_in = 16'h7777;
      @(negedge clk);
    end
    in_en = 1'b0;
    check({tag, " rows"}, 32'(rows), 16);
    check({tag, " ndone"}, 32'(ndone), 1);
    check({tag, " done_cycle"}, 32'(dcyc), 32'(first + 16));
    check({tag, " max_abs"}, max_abs, ref_max());
    check({tag, " pass"}, 32'(pass), 32'(ref_max() <= 32'h100));
    check({tag, " pass_tol1"}, 32'(t_pass), 32'(ref_max() <= 32'h1_0000));
    check({tag, " err"}, 32'(err), 32'(exp_err));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: timeout");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    in_en = 1'b0;
    out_valid = 1'b0;
    b_in = '0;
    x_in = '0;
    repeat (2) @(negedge clk);
    check("rst r_valid", 32'(r_valid), 0);
    check("rst done", 32'(done), 0);
    check("rst max_abs", max_abs, 0);
    check("rst pass", 32'(pass), 0);
    check("rst err", 32'(err), 0);
    reset = 1'b0;
    @(negedge clk);

    set_zero();
    send(0, 0);
    collect("t1", 0, -1, 0);

    set_t2();
    send(2, 0);
    collect("t2", 0, -1, 0);
    check("t2 max_abs_const", max_abs, 32'h000D_0000);

    set_zero();
    for (int i = 0; i < 16; i++) mx[i] = 32'h7FFF_FFFF;
    send(1, 0);
    collect("t3", 0, -1, 0);
    check("t3 max_abs_const", max_abs, 32'h7FFF_FFFF);

    set_zero();
    mb[4] = 16'd1;
    send(1, 0);
    collect("t4a", 0, -1, 0);
    check("t4a tol_pass", 32'(t_pass), 1);
    mb[4] = 16'd2;
    send(1, 0);
    collect("t4b", 0, -1, 0);
    check("t4b tol_pass", 32'(t_pass), 0);

    for (int p = 0; p < 3; p++) begin
      set_rand();
      send(3, 0);
      collect("rand", 0, -1, 0);
    end

    set_t2();
    send(1, 0);
    collect("t5abort", 0, 5, 0);
    send(1, 0);
    collect("t5rerun", 0, -1, 0);

    set_rand();
    send(1, 1);
    collect("t6", 1, -1, 1);
    set_rand();
    send(2, 0);
    collect("t6after", 0, -1, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
